// File: rtl/if_id_hazard_stage.sv
// IF/ID pipeline register with load-use stall and taken-branch flush control.
// Drives the fetch stage's PC write enable, PC mux select and redirect target.
module if_id_hazard_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] pc_plus4_in,
  input  logic              idex_mem_read,
  input  logic [REG_W-1:0]  idex_rt,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  output logic              pc_write,
  output logic              pc_sel,
  output logic [DATA_W-1:0] pc_target,
  output logic [DATA_W-1:0] id_instr,
  output logic [DATA_W-1:0] id_pc_plus4,
  output logic              id_valid,
  output logic              id_bubble,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t           state, state_nx;
  logic [REG_W-1:0] rs, rt;
  logic             hazard;
  logic             load_ifid, clear_ifid, stall_inc, flush_inc;

  assign rs        = id_instr[21 +: REG_W];
  assign rt        = id_instr[16 +: REG_W];
  assign hazard    = id_valid && idex_mem_read && (idex_rt != '0) &&
                     ((idex_rt == rs) || (idex_rt == rt));
  assign pc_target = branch_target;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nx;
  end

  // Branch redirect beats load-use stall in every state; reset forces safe outputs.
  always_comb begin
    state_nx   = state;
    pc_write   = 1'b1;
    pc_sel     = 1'b0;
    id_bubble  = 1'b0;
    load_ifid  = 1'b0;
    clear_ifid = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (reset) begin
      state_nx = RUN;
    end else if (branch_taken) begin
      pc_sel     = 1'b1;
      id_bubble  = 1'b1;
      clear_ifid = 1'b1;
      flush_inc  = 1'b1;
      state_nx   = FLUSH;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            pc_write  = 1'b0;
            id_bubble = 1'b1;
            stall_inc = 1'b1;
            state_nx  = STALL;
          end else begin
            load_ifid = 1'b1;
          end
        end
        STALL: begin
          load_ifid = 1'b1;
          state_nx  = RUN;
        end
        FLUSH: begin
          load_ifid = 1'b1;
          state_nx  = RUN;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_instr    <= '0;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
    end else if (clear_ifid) begin
      id_instr    <= '0;
      id_pc_plus4 <= '0;
      id_valid    <= 1'b0;
    end else if (load_ifid) begin
      id_instr    <= instr_in;
      id_pc_plus4 <= pc_plus4_in;
      id_valid    <= 1'b1;
    end
  end

  // Event counters stick at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
      if (flush_inc && (flush_count != '1)) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_hazard_stage.sv
// Scoreboard bench for if_id_hazard_stage; a narrow-counter instance shares
// the stimulus so counter saturation is reachable in a few cycles.
module tb_if_id_hazard_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr_in, pc_plus4_in, branch_target;
  logic        idex_mem_read, branch_taken;
  logic [4:0]  idex_rt;

  logic        pc_write, pc_sel, id_valid, id_bubble;
  logic [31:0] pc_target, id_instr, id_pc_plus4;
  logic [15:0] stall_count, flush_count;

  logic        s_pc_write, s_pc_sel, s_id_valid, s_id_bubble;
  logic [31:0] s_pc_target, s_id_instr, s_id_pc_plus4;
  logic [1:0]  s_stall_count, s_flush_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        pw, ps, bub;
    logic [31:0] tgt, instr, pc;
    logic        valid;
    logic [15:0] sc, fc;
    logic [1:0]  sc2, fc2;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] m_instr, m_pc;
  logic        m_valid, m_stalled;
  logic [15:0] m_sc, m_fc;
  logic [1:0]  m_sc2, m_fc2;

  always #5 clock = ~clock;

  if_id_hazard_stage dut (
    .clock(clock), .reset(reset), .instr_in(instr_in), .pc_plus4_in(pc_plus4_in),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_write(pc_write), .pc_sel(pc_sel),
    .pc_target(pc_target), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .id_valid(id_valid), .id_bubble(id_bubble), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  if_id_hazard_stage #(.DATA_W(32), .REG_W(5), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .instr_in(instr_in), .pc_plus4_in(pc_plus4_in),
    .idex_mem_read(idex_mem_read), .idex_rt(idex_rt), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_write(s_pc_write), .pc_sel(s_pc_sel),
    .pc_target(s_pc_target), .id_instr(s_id_instr), .id_pc_plus4(s_id_pc_plus4),
    .id_valid(s_id_valid), .id_bubble(s_id_bubble), .stall_count(s_stall_count),
    .flush_count(s_flush_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_instr = '0; m_pc = '0; m_valid = 1'b0; m_stalled = 1'b0;
    m_sc = '0; m_fc = '0; m_sc2 = '0; m_fc2 = '0;
  endtask

  // One clock of stimulus: expectation pushed at drive time, popped after the edge.
  task automatic step(input logic [31:0] ins, input logic [31:0] pc4, input logic mr,
                      input logic [4:0] rtd, input logic bt, input logic [31:0] tgt);
    exp_t e;
    exp_t got_e;
    logic haz;
    @(negedge clock);
    instr_in = ins; pc_plus4_in = pc4; idex_mem_read = mr; idex_rt = rtd;
    branch_taken = bt; branch_target = tgt;
    haz = m_valid && mr && (rtd != 5'd0) &&
          ((rtd == m_instr[25:21]) || (rtd == m_instr[20:16]));
    e.tgt = tgt;
    if (bt) begin
      e.pw = 1'b1; e.ps = 1'b1; e.bub = 1'b1;
      m_instr = '0; m_pc = '0; m_valid = 1'b0; m_stalled = 1'b0;
      if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      if (m_fc2 != 2'd3) m_fc2 = m_fc2 + 2'd1;
    end else if (haz && !m_stalled) begin
      e.pw = 1'b0; e.ps = 1'b0; e.bub = 1'b1;
      m_stalled = 1'b1;
      if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (m_sc2 != 2'd3) m_sc2 = m_sc2 + 2'd1;
    end else begin
      e.pw = 1'b1; e.ps = 1'b0; e.bub = 1'b0;
      m_instr = ins; m_pc = pc4; m_valid = 1'b1; m_stalled = 1'b0;
    end
    e.instr = m_instr; e.pc = m_pc; e.valid = m_valid;
    e.sc = m_sc; e.fc = m_fc; e.sc2 = m_sc2; e.fc2 = m_fc2;
    exp_q.push_back(e);
    #1;
    check("pc_write", 32'(pc_write), 32'(exp_q[0].pw));
    check("pc_sel", 32'(pc_sel), 32'(exp_q[0].ps));
    check("id_bubble", 32'(id_bubble), 32'(exp_q[0].bub));
    check("pc_target", pc_target, exp_q[0].tgt);
    check("sat_pc_write", 32'(s_pc_write), 32'(exp_q[0].pw));
    @(posedge clock);
    #1;
    got_e = exp_q.pop_front();
    check("id_instr", id_instr, got_e.instr);
    check("id_pc_plus4", id_pc_plus4, got_e.pc);
    check("id_valid", 32'(id_valid), 32'(got_e.valid));
    check("stall_count", 32'(stall_count), 32'(got_e.sc));
    check("flush_count", 32'(flush_count), 32'(got_e.fc));
    check("sat_stall_count", 32'(s_stall_count), 32'(got_e.sc2));
    check("sat_flush_count", 32'(s_flush_count), 32'(got_e.fc2));
  endtask

  initial begin
    reset = 1'b1;
    instr_in = '0; pc_plus4_in = '0; idex_mem_read = 1'b0; idex_rt = '0;
    branch_taken = 1'b1; branch_target = 32'h0000_0100;
    model_reset();
    #1;
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_id_valid", 32'(id_valid), 32'h0);
    check("rst_pc_write", 32'(pc_write), 32'h1);
    check("rst_pc_sel", 32'(pc_sel), 32'h0);
    check("rst_id_bubble", 32'(id_bubble), 32'h0);
    check("rst_stall_count", 32'(stall_count), 32'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    branch_taken = 1'b0;
    reset = 1'b0;

    // straight-line fetch
    step(32'h20080005, 32'h4, 1'b0, 5'd0, 1'b0, 32'h0);
    check("t2_instr0", id_instr, 32'h20080005);
    step(32'h20090003, 32'h8, 1'b0, 5'd0, 1'b0, 32'h0);
    check("t2_pc1", id_pc_plus4, 32'h8);

    // load-use on rs=8
    step(32'h01095020, 32'hC, 1'b0, 5'd0, 1'b0, 32'h0);
    step(32'h0000AAAA, 32'h10, 1'b1, 5'd8, 1'b0, 32'h0);
    check("t3_held", id_instr, 32'h01095020);
    check("t3_stalls", 32'(stall_count), 32'h1);
    step(32'h0000AAAA, 32'h10, 1'b0, 5'd0, 1'b0, 32'h0);
    check("t3_resume", id_instr, 32'h0000AAAA);
    step(32'h0000BBBB, 32'h14, 1'b0, 5'd0, 1'b0, 32'h0);

    // taken branch to 0x40
    step(32'h11111111, 32'h18, 1'b0, 5'd0, 1'b1, 32'h40);
    check("t4_flushes", 32'(flush_count), 32'h1);
    step(32'h22222222, 32'h44, 1'b0, 5'd0, 1'b0, 32'h0);
    check("t4_target_pc", id_pc_plus4, 32'h44);

    // branch and hazard together
    step(32'h01095020, 32'h48, 1'b0, 5'd0, 1'b0, 32'h0);
    step(32'h33333333, 32'h4C, 1'b1, 5'd8, 1'b1, 32'h80);
    check("t5_stalls", 32'(stall_count), 32'h1);
    check("t5_flushes", 32'(flush_count), 32'h2);
    step(32'h44444444, 32'h84, 1'b0, 5'd0, 1'b0, 32'h0);

    // rt=0 never stalls
    step(32'h00000000, 32'h88, 1'b0, 5'd0, 1'b0, 32'h0);
    step(32'h00000020, 32'h8C, 1'b1, 5'd0, 1'b0, 32'h0);
    check("t6_no_stall", 32'(stall_count), 32'h1);

    // repeated load-use and branches saturate the narrow counters
    for (int i = 0; i < 8; i++)
      step(32'h01095020, 32'h90, 1'b1, 5'd8, 1'b0, 32'h0);
    check("t6_sat_stall", 32'(s_stall_count), 32'h3);
    for (int i = 0; i < 4; i++)
      step(32'h55555555, 32'h94, 1'b0, 5'd0, 1'b1, 32'hC0);
    check("t6_sat_flush", 32'(s_flush_count), 32'h3);
    step(32'h66666666, 32'hC4, 1'b0, 5'd0, 1'b0, 32'h0);

    // reset asserted while in STALL
    step(32'h01095020, 32'hC8, 1'b0, 5'd0, 1'b0, 32'h0);
    step(32'h77777777, 32'hCC, 1'b1, 5'd8, 1'b0, 32'h0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("t1_instr", id_instr, 32'h0);
    check("t1_valid", 32'(id_valid), 32'h0);
    check("t1_stalls", 32'(stall_count), 32'h0);
    check("t1_flushes", 32'(flush_count), 32'h0);
    check("t1_pc_write", 32'(pc_write), 32'h1);
    check("t1_bubble", 32'(id_bubble), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(32'h88888888, 32'hD0, 1'b0, 5'd0, 1'b0, 32'h0);
    check("t1_run_load", id_instr, 32'h88888888);
    step(32'h99999999, 32'hD4, 1'b0, 5'd0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
